// File: rtl/sys_array_os_ctrl_pkg.sv
// Shared types and default dimensions for the output-stationary systolic array sequencer.
package sys_array_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_FEED,
      ST_FLUSH,
      ST_DRAIN,
      ST_DONE
   } ctrl_state_e;

   localparam int DEF_SIZE    = 16;
   localparam int DEF_ADDR_W  = 12;
   localparam int DEF_PE_LAT  = 3;
   localparam int DEF_BUF_LAT = 1;

   // Cycles after the last read until the far-corner PE has committed its final MAC.
   function automatic int flush_cycles(input int size, input int pe_lat, input int buf_lat);
      return buf_lat + 2 * (size - 1) + pe_lat + 1;
   endfunction

   localparam int FLUSH_CYC = flush_cycles(DEF_SIZE, DEF_PE_LAT, DEF_BUF_LAT);
   localparam int ROW_IDX_W = $clog2(DEF_SIZE);

endpackage

// File: rtl/sys_array_os_ctrl_if.sv
// Result-row stream between the sequencer (master) and the downstream consumer (slave).
// valid/ready: a row transfers on any cycle where out_valid and out_ready are both high;
// once out_valid rises it stays high with out_row_idx stable until that transfer happens.
interface sys_array_os_ctrl_if #(
   parameter int ROW_W = 4
);
   logic             out_valid;
   logic             out_ready;
   logic [ROW_W-1:0] out_row_idx;

   modport master (output out_valid, output out_row_idx, input out_ready);
   modport slave  (input out_valid, input out_row_idx, output out_ready);
endinterface

// File: rtl/sys_array_os_ctrl_skew.sv
// SIZE-wide valid delay line: bit i is the input delayed i cycles, bit 0 is the input itself.
module skew_shift #(
   parameter int SIZE = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr,
   input  logic            v_in,
   output logic [SIZE-1:0] v_out
);

   logic [SIZE-1:1] sr_q;

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         sr_q <= '0;
      end else begin
         sr_q[1] <= v_in;
         for (int i = 2; i < SIZE; i++) begin
            sr_q[i] <= sr_q[i-1];
         end
      end
   end

   assign v_out = {sr_q, v_in};

endmodule

// File: rtl/sys_array_os_ctrl.sv
// Sequencer for the output-stationary systolic array: clear, skewed operand feed,
// pipeline flush, then row-by-row result drain over a valid/ready stream.
module sys_array_os_ctrl
   import sys_array_pkg::*;
#(
   parameter int SIZE    = DEF_SIZE,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int PE_LAT  = DEF_PE_LAT,
   parameter int BUF_LAT = DEF_BUF_LAT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic [ADDR_W:0]      k_len,
   output logic                 busy,
   output logic                 done,
   output logic                 buf_rd_en,
   output logic [ADDR_W-1:0]    buf_rd_addr,
   output logic                 sa_acc_clear,
   output logic [SIZE-1:0]      sa_row_valid,
   output logic [SIZE-1:0]      sa_col_valid,
   output logic                 sa_shift_en,
   sys_array_os_ctrl_if.master  res,
   output ctrl_state_e          dbg_state
);

   localparam int FLUSH_N = flush_cycles(SIZE, PE_LAT, BUF_LAT);
   localparam int RW      = $clog2(SIZE);
   localparam int CNT_W   = ADDR_W + 1;

   ctrl_state_e        state_q, state_d;
   logic [ADDR_W:0]    k_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [RW-1:0]      row_q;
   logic [BUF_LAT-1:0] feed_pipe_q;
   logic               feed_v;
   logic               hs;
   logic               last_feed;
   logic               flush_end;
   logic               last_row;

   assign hs        = (state_q == ST_DRAIN) && res.out_ready;
   // FEED length is counted, so k_len = 2^ADDR_W works even though the address wraps.
   assign last_feed = (cnt_q == (k_q - CNT_W'(1)));
   assign flush_end = (cnt_q == CNT_W'(FLUSH_N - 1));
   assign last_row  = (row_q == RW'(SIZE - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (start) state_d = ST_CLEAR;
         ST_CLEAR: state_d = (k_q != '0) ? ST_FEED : ST_DRAIN;
         ST_FEED:  if (last_feed) state_d = ST_FLUSH;
         ST_FLUSH: if (flush_end) state_d = ST_DRAIN;
         ST_DRAIN: if (hs && last_row) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      if (abort) state_d = ST_IDLE;
   end

   always_comb begin
      busy         = (state_q != ST_IDLE);
      done         = (state_q == ST_DONE);
      sa_acc_clear = (state_q == ST_CLEAR);
      buf_rd_en    = (state_q == ST_FEED);
      buf_rd_addr  = buf_rd_en ? cnt_q[ADDR_W-1:0] : '0;
      res.out_valid   = (state_q == ST_DRAIN);
      res.out_row_idx = res.out_valid ? row_q : '0;
      sa_shift_en  = hs;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         k_q         <= '0;
         cnt_q       <= '0;
         row_q       <= '0;
         feed_pipe_q <= '0;
      end else begin
         if ((state_q == ST_IDLE) && start && !abort) k_q <= k_len;

         if (abort || (state_d != state_q))                  cnt_q <= '0;
         else if ((state_q == ST_FEED) || (state_q == ST_FLUSH)) cnt_q <= cnt_q + CNT_W'(1);

         if (abort || (state_q != ST_DRAIN)) row_q <= '0;
         else if (hs)                        row_q <= row_q + RW'(1);

         if (abort) begin
            feed_pipe_q <= '0;
         end else begin
            feed_pipe_q[0] <= buf_rd_en;
            for (int i = 1; i < BUF_LAT; i++) begin
               feed_pipe_q[i] <= feed_pipe_q[i-1];
            end
         end
      end
   end

   // Operand data emerges BUF_LAT cycles after the read; skew starts from there.
   assign feed_v = feed_pipe_q[BUF_LAT-1];

   skew_shift #(.SIZE(SIZE)) u_row_skew (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (abort),
      .v_in  (feed_v),
      .v_out (sa_row_valid)
   );

   skew_shift #(.SIZE(SIZE)) u_col_skew (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (abort),
      .v_in  (feed_v),
      .v_out (sa_col_valid)
   );

   assign dbg_state = state_q;

endmodule
